// File: rtl/ptm_pkg.sv
// Shared definitions for the pipeline trace monitor: FSM state encoding and
// the width of one trace entry (per stage {valid, payload}).
package ptm_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ARMED     = 2'd1,
        ST_TRIGGERED = 2'd2,
        ST_DONE      = 2'd3
    } ptm_state_e;

    localparam int PTM_STATE_W = 2;

    function automatic int entry_width(input int data_w, input int stages);
        return stages * (data_w + 1);
    endfunction

endpackage

// File: rtl/pipeline_trace_monitor_if.sv
// Tap and readout bundle between the cpu core and the trace monitor.
// The core/bench side uses master, the monitor uses slave.
interface pipeline_trace_monitor_if #(
    parameter int DATA_W = 16,
    parameter int STAGES = 4
);
    import ptm_pkg::*;

    localparam int ENTRY_W = entry_width(DATA_W, STAGES);

    logic [STAGES*DATA_W-1:0] stage_word;
    logic [STAGES-1:0]        stage_valid;
    logic [STAGES-1:0]        stage_hold;
    logic [STAGES-1:0]        stage_flush;
    logic                     retire;
    logic                     rd_req;
    logic [ENTRY_W-1:0]       rd_data;
    logic                     rd_valid;
    logic                     rd_last;

    modport master (
        output stage_word, stage_valid, stage_hold, stage_flush, retire, rd_req,
        input  rd_data, rd_valid, rd_last
    );

    modport slave (
        input  stage_word, stage_valid, stage_hold, stage_flush, retire, rd_req,
        output rd_data, rd_valid, rd_last
    );

endinterface

// File: rtl/ptm_trace_ram.sv
// Single-write, single-read trace memory with a registered read port.
// Only the read register is reset, which block RAM output registers support.
module ptm_trace_ram #(
    parameter int WIDTH = 68,
    parameter int DEPTH = 16
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [WIDTH-1:0]         rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/pipeline_trace_monitor.sv
// Pipeline trace monitor: circular capture of all inter-stage buffers with a
// post-trigger window and oldest-first readout. Counters built with PTM_PERF_CNT_EN.
module pipeline_trace_monitor
    import ptm_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int STAGES = 4,
    parameter int DEPTH  = 16,
    parameter int POST   = 4,
    parameter int CNT_W  = 32
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      arm,
    input  logic                      trigger,
    pipeline_trace_monitor_if.slave   bus,
    output logic [PTM_STATE_W-1:0]    state,
    output logic [$clog2(DEPTH):0]    fill,
    output logic [CNT_W-1:0]          cycle_count,
    output logic [CNT_W-1:0]          retire_count,
    output logic [CNT_W-1:0]          stall_count,
    output logic [CNT_W-1:0]          flush_count
);

    localparam int ADDR_W  = $clog2(DEPTH);
    localparam int FILL_W  = ADDR_W + 1;
    localparam int ENTRY_W = entry_width(DATA_W, STAGES);

    ptm_state_e          state_q;
    logic [ADDR_W-1:0]   wr_ptr;
    logic [ADDR_W-1:0]   rd_ptr;
    logic [FILL_W-1:0]   fill_q;
    logic [FILL_W-1:0]   rd_cnt;
    logic [FILL_W-1:0]   post_left;
    logic                capturing;
    logic                rd_accept;
    logic                rd_valid_q;
    logic                rd_last_q;
    logic [ENTRY_W-1:0]  entry;
    logic [ENTRY_W-1:0]  ram_q;

    always_comb begin
        entry = '0;
        for (int s = 0; s < STAGES; s++) begin
            entry[s*(DATA_W+1) +: DATA_W+1] = {bus.stage_valid[s], bus.stage_word[s*DATA_W +: DATA_W]};
        end
    end

    // arm takes priority over everything, so its own cycle never captures or reads
    assign capturing = (state_q == ST_ARMED || state_q == ST_TRIGGERED) && !arm;
    assign rd_accept = (state_q == ST_DONE) && !arm && bus.rd_req && !rd_valid_q
                       && (rd_cnt < fill_q);

    // Oldest entry sits fill slots behind wr_ptr; a full buffer wraps to wr_ptr itself
    assign rd_ptr = wr_ptr - fill_q[ADDR_W-1:0] + rd_cnt[ADDR_W-1:0];

    ptm_trace_ram #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_ram (
        .clock   (clock),
        .reset   (reset),
        .wr_en   (capturing),
        .wr_addr (wr_ptr),
        .wr_data (entry),
        .rd_en   (rd_accept),
        .rd_addr (rd_ptr),
        .rd_data (ram_q)
    );

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            wr_ptr     <= '0;
            fill_q     <= '0;
            rd_cnt     <= '0;
            post_left  <= '0;
            rd_valid_q <= 1'b0;
            rd_last_q  <= 1'b0;
        end else begin
            rd_valid_q <= rd_accept;
            rd_last_q  <= rd_accept && (rd_cnt + FILL_W'(1) == fill_q);
            if (rd_accept) begin
                rd_cnt <= rd_cnt + FILL_W'(1);
            end
            if (capturing) begin
                wr_ptr <= wr_ptr + ADDR_W'(1);
                if (fill_q != FILL_W'(DEPTH)) begin
                    fill_q <= fill_q + FILL_W'(1);
                end
            end
            if (arm) begin
                state_q   <= ST_ARMED;
                wr_ptr    <= '0;
                fill_q    <= '0;
                rd_cnt    <= '0;
                post_left <= '0;
            end else begin
                case (state_q)
                    ST_ARMED: begin
                        if (trigger) begin
                            if (POST == 0) begin
                                state_q <= ST_DONE;
                            end else begin
                                state_q   <= ST_TRIGGERED;
                                post_left <= FILL_W'(POST);
                            end
                        end
                    end
                    ST_TRIGGERED: begin
                        post_left <= post_left - FILL_W'(1);
                        if (post_left == FILL_W'(1)) begin
                            state_q <= ST_DONE;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign state        = state_q;
    assign fill         = fill_q;
    assign bus.rd_data  = ram_q;
    assign bus.rd_valid = rd_valid_q;
    assign bus.rd_last  = rd_last_q;

`ifdef PTM_PERF_CNT_EN
    localparam int POP_W = $clog2(STAGES + 1);

    logic [CNT_W-1:0] cyc_q;
    logic [CNT_W-1:0] ret_q;
    logic [CNT_W-1:0] stall_q;
    logic [CNT_W-1:0] flush_q;
    logic [POP_W-1:0] flush_pop;
    logic [CNT_W:0]   flush_sum;

    always_comb begin
        flush_pop = '0;
        for (int s = 0; s < STAGES; s++) begin
            flush_pop = flush_pop + POP_W'(bus.stage_flush[s]);
        end
    end

    assign flush_sum = {1'b0, flush_q} + (CNT_W+1)'(flush_pop);

    // All counters stick at all-ones instead of wrapping
    always_ff @(posedge clock) begin
        if (!reset) begin
            cyc_q   <= '0;
            ret_q   <= '0;
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if (!(&cyc_q)) begin
                cyc_q <= cyc_q + CNT_W'(1);
            end
            if (bus.retire && !(&ret_q)) begin
                ret_q <= ret_q + CNT_W'(1);
            end
            if ((|bus.stage_hold) && !(&stall_q)) begin
                stall_q <= stall_q + CNT_W'(1);
            end
            flush_q <= flush_sum[CNT_W] ? '1 : flush_sum[CNT_W-1:0];
        end
    end

    assign cycle_count  = cyc_q;
    assign retire_count = ret_q;
    assign stall_count  = stall_q;
    assign flush_count  = flush_q;
`else
    logic unused_perf;
    assign unused_perf  = ^{bus.stage_hold, bus.stage_flush, bus.retire};
    assign cycle_count  = '0;
    assign retire_count = '0;
    assign stall_count  = '0;
    assign flush_count  = '0;
`endif

endmodule
